seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector and the successor to the fixed five-bit `10011` detector. It has a run-time programmable pattern of 1 to MAX_LEN bits and selectable overlapping or non-overlapping matching. It also qualifies input bits with a valid strobe and keeps a saturating match counter. It sits on a serial input stream and produces a registered one-cycle match pulse `z` for downstream control logic.

---
 rtl/seq_detect_param_if.sv | 37 +++
 rtl/seq_detect_param.sv | 104 ++++++++++
 tb/tb_seq_detect_param.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial stream, configuration and status bundle for seq_detect_param
//
// Ports carried (master drives, slave is the detector):
//   x, in_valid        serial bit and its qualifier
//   cfg_load           strobe latching pattern / pat_len / overlap
//   pattern, pat_len   right-aligned pattern and its length
//   overlap            1 = overlapping matches, 0 = non-overlapping
//   count_clr          synchronous clear of match_cnt
//   z                  registered one-cycle match pulse
//   match_cnt          saturating match count
//   cfg_err            one-cycle pulse on a rejected cfg_load
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               x;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               count_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output x, in_valid, cfg_load, pattern, pat_len, overlap, count_clr,
        input  z, match_cnt, cfg_err
    );

    modport slave (
        input  x, in_valid, cfg_load, pattern, pat_len, overlap, count_clr,
        output z, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - programmable serial bit-pattern detector with saturating match counter
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   seq_detect_param_if.slave: x/in_valid stream in, cfg_load/pattern/
//         pat_len/overlap configuration, count_clr, z/match_cnt/cfg_err out
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b00010011),
    parameter logic [LEN_W-1:0]   RST_LEN     = LEN_W'(5),
    parameter logic               RST_OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_param_if.slave bus
);
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl;
    logic               z_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic               accept;
    logic               cfg_ok;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_nxt;
    logic [LEN_W:0]     fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN:0]   diff;
    logic               match;
    logic               cnt_sat;

    assign accept   = bus.in_valid && !bus.cfg_load;
    assign cfg_ok   = (bus.pat_len != '0) && (int'(bus.pat_len) <= MAX_LEN);
    assign hist_nxt = {hist[MAX_LEN-2:0], bus.x};
    assign fill_inc = {1'b0, fill} + (LEN_W+1)'(1);
    assign fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    assign cnt_sat  = &cnt_q;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(cfg_len));
        end
    end

    // Compare the window as it will be after this bit shifts in. The extra top
    // bit is the one falling out of the history and is always masked off.
    assign diff  = ({hist, bus.x} ^ {1'b0, cfg_pat}) & {1'b0, len_mask};
    assign match = accept && (fill_inc >= {1'b0, cfg_len}) && (diff == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist    <= '0;
            fill    <= '0;
            cfg_pat <= RST_PATTERN;
            cfg_len <= RST_LEN;
            cfg_ovl <= RST_OVERLAP;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            z_q   <= 1'b0;
            err_q <= 1'b0;
            if (bus.cfg_load) begin
                // cfg_load takes priority; any bit presented this cycle is dropped
                if (cfg_ok) begin
                    cfg_pat <= bus.pattern;
                    cfg_len <= bus.pat_len;
                    cfg_ovl <= bus.overlap;
                    hist    <= '0;
                    fill    <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (accept) begin
                hist <= hist_nxt;
                if (match) begin
                    z_q  <= 1'b1;
                    // non-overlap: force a full refill so no bit is reused
                    fill <= cfg_ovl ? fill_nxt : '0;
                end else begin
                    fill <= fill_nxt;
                end
            end

            if (bus.count_clr) begin
                cnt_q <= match ? CNT_W'(1) : '0;
            end else if (match && !cnt_sat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param
module tb_seq_detect_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) bus ();
    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) bus2 ();

    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    assign bus2.x         = bus.x;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.cfg_load  = bus.cfg_load;
    assign bus2.pattern   = bus.pattern;
    assign bus2.pat_len   = bus.pat_len;
    assign bus2.overlap   = bus.overlap;
    assign bus2.count_clr = bus.count_clr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the bits accepted since the last restart, oldest first.
    bit        hq[$];
    bit [7:0]  m_pat;
    int        m_len;
    bit        m_ovl;
    bit        m_z;
    bit        m_err;
    int        m_cnt;
    int        m_cnt2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        m_pat = 8'b00010011;
        m_len = 5;
        m_ovl = 1'b1;
        m_z = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_step();
        bit match;
        match = 0;
        m_err = 0;
        if (bus.cfg_load) begin
            if (bus.pat_len >= 1 && int'(bus.pat_len) <= MAX_LEN) begin
                m_pat = bus.pattern;
                m_len = int'(bus.pat_len);
                m_ovl = bus.overlap;
                hq.delete();
            end else begin
                m_err = 1;
            end
        end else if (bus.in_valid) begin
            hq.push_back(bus.x);
            if (hq.size() > MAX_LEN) void'(hq.pop_front());
            if (hq.size() >= m_len) begin
                match = 1;
                for (int k = 0; k < m_len; k++)
                    if (hq[hq.size()-1-k] != m_pat[k]) match = 0;
            end
            if (match && !m_ovl) hq.delete();
        end
        m_z = match;
        if (bus.count_clr) begin
            m_cnt  = match ? 1 : 0;
            m_cnt2 = match ? 1 : 0;
        end else if (match) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("z", 32'(bus.z), 32'(m_z));
        chk("cnt", 32'(bus.match_cnt), 32'(m_cnt));
        chk("cnt2", 32'(bus2.match_cnt), 32'(m_cnt2));
        chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    endtask

    task automatic drive(input bit xi, input bit vi, input bit cl, input bit [7:0] pat,
                         input bit [3:0] len, input bit ovl, input bit clr);
        bus.x = xi; bus.in_valid = vi; bus.cfg_load = cl;
        bus.pattern = pat; bus.pat_len = len; bus.overlap = ovl; bus.count_clr = clr;
        tick();
        bus.in_valid = 0; bus.cfg_load = 0; bus.count_clr = 0;
    endtask

    task automatic bit_in(input bit b);
        drive(b, 1, 0, 8'h00, 4'd0, 0, 0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 8'h00, 4'd0, 0, 0);
    endtask

    task automatic load(input bit [7:0] pat, input bit [3:0] len, input bit ovl);
        drive(0, 0, 1, pat, len, ovl, 0);
    endtask

    task automatic clr();
        drive(0, 0, 0, 8'h00, 4'd0, 0, 1);
    endtask

    task automatic mid_reset();
        #2 rst = 0;
        #2;
        chk("rst_z", 32'(bus.z), 0);
        chk("rst_cnt", 32'(bus.match_cnt), 0);
        chk("rst_err", 32'(bus.cfg_err), 0);
        chk("rst_fill", 32'(dut.fill), 0);
        model_reset();
        rst = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [8:0] s1;
        bit [4:0] s3;
        bit [7:0] sa5;
        bit [7:0] rp;
        int r;

        bus.x = 0; bus.in_valid = 0; bus.cfg_load = 0; bus.pattern = '0;
        bus.pat_len = '0; bus.overlap = 0; bus.count_clr = 0;
        model_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_z", 32'(bus.z), 0);
        chk("init_cnt", 32'(bus.match_cnt), 0);
        chk("init_fill", 32'(dut.fill), 0);
        #2 rst = 1;

        // default pattern 10011, overlapping
        s1 = 9'b100110011;
        for (int i = 0; i < 9; i++) begin
            bit_in(s1[8-i]);
            chk("t1_z", 32'(bus.z), 32'(i == 4 || i == 8));
        end
        chk("t1_cnt", 32'(bus.match_cnt), 2);

        // 101, non-overlapping then overlapping
        s3 = 5'b10101;
        clr();
        load(8'b00000101, 4'd3, 0);
        for (int i = 0; i < 5; i++) begin
            bit_in(s3[4-i]);
            chk("t2_z", 32'(bus.z), 32'(i == 2));
        end
        chk("t2_cnt", 32'(bus.match_cnt), 1);
        clr();
        load(8'b00000101, 4'd3, 1);
        for (int i = 0; i < 5; i++) begin
            bit_in(s3[4-i]);
            chk("t2o_z", 32'(bus.z), 32'(i == 2 || i == 4));
        end
        chk("t2o_cnt", 32'(bus.match_cnt), 2);

        // gapped input
        clr();
        load(8'b00010011, 4'd5, 1);
        for (int i = 0; i < 5; i++) begin
            bit_in(s1[8-i]);
            chk("t3_z", 32'(bus.z), 32'(i == 4));
            idle(); chk("t3_idle", 32'(bus.z), 0);
            idle(); chk("t3_idle", 32'(bus.z), 0);
        end
        chk("t3_cnt", 32'(bus.match_cnt), 1);

        // rejected configurations keep detection and history
        load(8'hFF, 4'd0, 0);
        chk("t4_err0", 32'(bus.cfg_err), 1);
        idle();
        chk("t4_errpulse", 32'(bus.cfg_err), 0);
        load(8'hFF, 4'd9, 0);
        chk("t4_err9", 32'(bus.cfg_err), 1);
        for (int i = 0; i < 5; i++) begin
            bit_in(s1[8-i]);
            chk("t4_z", 32'(bus.z), 32'(i == 4));
        end
        // full-length pattern, also with cfg_load and in_valid together
        drive(1, 1, 1, 8'hA5, 4'd8, 1, 0);
        chk("t4_loaderr", 32'(bus.cfg_err), 0);
        sa5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            bit_in(sa5[7-i]);
            chk("t4_a5", 32'(bus.z), 32'(i == 7));
        end

        // counter saturation and clear-on-match
        clr();
        load(8'h01, 4'd1, 1);
        for (int i = 0; i < 5; i++) bit_in(1);
        chk("t5_cnt2sat", 32'(bus2.match_cnt), 3);
        chk("t5_cnt", 32'(bus.match_cnt), 5);
        drive(1, 1, 0, 8'h00, 4'd0, 0, 1);
        chk("t5_clrmatch", 32'(bus.match_cnt), 1);
        chk("t5_clrmatch2", 32'(bus2.match_cnt), 1);
        for (int i = 0; i < 260; i++) begin
            bit_in(1);
            chk("t5_zcont", 32'(bus.z), 1);
        end
        chk("t5_cntsat", 32'(bus.match_cnt), 255);

        // asynchronous reset mid-stream
        load(8'b00010011, 4'd5, 1);
        for (int i = 0; i < 4; i++) bit_in(s1[8-i]);
        mid_reset();
        bit_in(1);
        chk("t6_one", 32'(bus.z), 0);
        for (int i = 0; i < 5; i++) begin
            bit_in(s1[8-i]);
            chk("t6_z", 32'(bus.z), 32'(i == 4));
        end

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            rp = 8'($urandom);
            if (r < 5)
                drive(1'($urandom), 1'($urandom), 1, rp, 4'($urandom_range(0, 10)),
                      1'($urandom), 0);
            else
                drive(1'($urandom), r < 80, 0, rp, 4'($urandom_range(0, 10)),
                      1'($urandom), $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
